// File: rtl/audio_i2s_rx.sv
`default_nettype none
// ============================================================================
// audio_i2s_rx : I2S capture from the codec ADC line into a small pair FIFO,
//                aligned to the externally driven lrck, with lock/error status.
// Revision     : 1.0
// ============================================================================
module audio_i2s_rx #(
  parameter int SAMPLE_PHASE = 2,
  parameter int FIFO_DEPTH   = 2
) (
  input  logic               clk_12_288_mhz,
  input  logic               reset,
  input  logic               lrck,
  input  logic               adc,
  output logic signed [15:0] sound_l,
  output logic signed [15:0] sound_r,
  output logic               sample_valid,
  input  logic               sample_ready,
  output logic               locked,
  output logic               frame_error,
  output logic               overflow
);

  localparam int             PW         = $clog2(FIFO_DEPTH);
  localparam logic [1:0]     PHASE      = SAMPLE_PHASE[1:0];
  localparam logic [PW:0]    FULL_COUNT = FIFO_DEPTH[PW:0];

  typedef enum logic [0:0] {UNLOCKED = 1'b0, LOCKED = 1'b1} state_t;

  state_t        state;
  logic          lrck_d;
  logic [7:0]    cnt;
  logic [15:0]   shift_reg;
  logic [15:0]   left_reg;
  logic [15:0]   mem_l [FIFO_DEPTH];
  logic [15:0]   mem_r [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic [15:0]   last_l;
  logic [15:0]   last_r;

  logic          fall;
  logic [7:0]    idx;
  logic          mismatch;
  logic          active;
  logic          capture;
  logic          push;
  logic          pop;
  logic          full;
  logic          write;

  assign fall     = !lrck && lrck_d;
  assign idx      = fall ? 8'd0 : cnt;
  assign mismatch = (state == LOCKED) && (lrck != idx[7]);
  // A cycle that breaks alignment must not contribute to the frame it kills.
  assign active   = (state == LOCKED) && !mismatch;
  assign capture  = active && (idx[1:0] == PHASE) &&
                    (idx[6:2] >= 5'd1) && (idx[6:2] <= 5'd16);
  assign push     = active && (idx == 8'd196);

  assign sample_valid = (count != '0);
  assign pop          = sample_valid && sample_ready;
  assign full         = (count == FULL_COUNT);
  assign write        = push && (!full || pop);
  assign locked       = (state == LOCKED);

  // When empty the head shows the most recently popped pair.
  assign sound_l = sample_valid ? mem_l[rd_ptr] : last_l;
  assign sound_r = sample_valid ? mem_r[rd_ptr] : last_r;

  always_ff @(posedge clk_12_288_mhz) begin
    if (reset) begin
      state       <= UNLOCKED;
      lrck_d      <= 1'b0;
      cnt         <= 8'd0;
      shift_reg   <= 16'd0;
      left_reg    <= 16'd0;
      frame_error <= 1'b0;
      overflow    <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      last_l      <= 16'd0;
      last_r      <= 16'd0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_l[i] <= 16'd0;
        mem_r[i] <= 16'd0;
      end
    end else begin
      lrck_d      <= lrck;
      cnt         <= idx + 8'd1;
      frame_error <= 1'b0;

      case (state)
        UNLOCKED: if (fall) state <= LOCKED;
        LOCKED: begin
          if (mismatch) begin
            state       <= UNLOCKED;
            frame_error <= 1'b1;
          end
        end
        default: state <= UNLOCKED;
      endcase

      if (capture) shift_reg <= {shift_reg[14:0], adc};
      if (active && (idx == 8'd68)) left_reg <= shift_reg;

      if (write) begin
        mem_l[wr_ptr] <= left_reg;
        mem_r[wr_ptr] <= shift_reg;
        wr_ptr        <= wr_ptr + PW'(1);
      end
      if (push && full && !pop) overflow <= 1'b1;

      if (pop) begin
        last_l <= mem_l[rd_ptr];
        last_r <= mem_r[rd_ptr];
        rd_ptr <= rd_ptr + PW'(1);
      end

      case ({write, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_audio_i2s_rx.sv
`default_nettype none
// ============================================================================
// tb_audio_i2s_rx : directed bench driving a model codec frame by frame.
// Revision        : 1.0
// ============================================================================
module tb_audio_i2s_rx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset;
  logic               lrck;
  logic               adc;
  logic               sample_ready;
  logic signed [15:0] sound_l;
  logic signed [15:0] sound_r;
  logic               sample_valid;
  logic               locked;
  logic               frame_error;
  logic               overflow;

  int          compared   = 0;
  int          mismatched = 0;
  int          err_pulses = 0;
  int          err_at     = -1;
  int          valid_rise = -1;
  logic        lock_at_err;
  logic        lock_p0;
  logic [31:0] got[$];

  audio_i2s_rx #(.SAMPLE_PHASE(2), .FIFO_DEPTH(2)) dut (
    .clk_12_288_mhz (clk),
    .reset          (reset),
    .lrck           (lrck),
    .adc            (adc),
    .sound_l        (sound_l),
    .sound_r        (sound_r),
    .sample_valid   (sample_valid),
    .sample_ready   (sample_ready),
    .locked         (locked),
    .frame_error    (frame_error),
    .overflow       (overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] got_at(input int i);
    return (i < got.size()) ? got[i] : 32'hDEAD_DEAD;
  endfunction

  // One clock: drive inputs, log any pop taken at the coming edge, then settle.
  task automatic step(input logic l, input logic d);
    lrck = l;
    adc  = d;
    if (sample_valid && sample_ready) got.push_back({sound_l, sound_r});
    @(posedge clk);
    #1;
    if (frame_error) err_pulses++;
  endtask

  // Model codec: positions first..last-1 of a frame, lrck high from rise_at,
  // bit 16-s of the half's word held for the whole of slot s (1..16).
  task automatic frame(input logic [15:0] l_word, input logic [15:0] r_word,
                       input int rise_at, input int first, input int last);
    logic [15:0] w;
    int          s;
    err_at     = -1;
    valid_rise = -1;
    for (int p = first; p < last; p++) begin
      w = (p < 128) ? l_word : r_word;
      s = (p % 128) / 4;
      step(p >= rise_at, (s >= 1 && s <= 16) ? w[16-s] : 1'b0);
      if (p == 0) lock_p0 = locked;
      if (frame_error && err_at < 0) begin
        err_at      = p;
        lock_at_err = locked;
      end
      if (sample_valid && valid_rise < 0) valid_rise = p;
    end
  endtask

  initial begin
    reset = 1'b1; lrck = 1'b1; adc = 1'b0; sample_ready = 1'b0;
    repeat (3) step(1'b1, 1'b0);
    chk("rst_sound_l", 32'(sound_l), 32'h0);
    chk("rst_sound_r", 32'(sound_r), 32'h0);
    chk("rst_valid", 32'(sample_valid), 32'h0);
    chk("rst_locked", 32'(locked), 32'h0);
    chk("rst_ferr", 32'(frame_error), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);
    reset = 1'b0;
    repeat (4) step(1'b1, 1'b0);
    chk("no_lock_before_fall", 32'(locked), 32'h0);

    // First frame after reset
    frame(16'h8001, 16'h7FFE, 128, 0, 256);
    chk("lock_first_fall", 32'(lock_p0), 32'h1);
    chk("valid_visible_idx197", 32'(valid_rise), 32'd196);
    chk("pair1", {sound_l, sound_r}, 32'h8001_7FFE);
    chk("no_err_pulse", 32'(err_pulses), 32'h0);

    // Continuous delivery, consumer always ready
    sample_ready = 1'b1;
    got.delete();
    for (int n = 1; n <= 8; n++) frame(16'(n), 16'(-n), 128, 0, 256);
    chk("stream_count", 32'(got.size()), 32'd9);
    chk("stream_first", got_at(0), 32'h8001_7FFE);
    for (int n = 1; n <= 8; n++) chk("stream_pair", got_at(n), {16'(n), 16'(-n)});
    chk("stream_no_ovf", 32'(overflow), 32'h0);
    chk("stream_no_err", 32'(err_pulses), 32'h0);

    // Back-pressure: fill, then overflow
    sample_ready = 1'b0;
    got.delete();
    frame(16'd9, 16'(-9), 128, 0, 256);
    frame(16'd10, 16'(-10), 128, 0, 256);
    chk("full_no_ovf", 32'(overflow), 32'h0);
    frame(16'd11, 16'(-11), 128, 0, 256);
    frame(16'd12, 16'(-12), 128, 0, 256);
    chk("ovf_set", 32'(overflow), 32'h1);
    chk("ovf_valid", 32'(sample_valid), 32'h1);
    chk("ovf_head", {sound_l, sound_r}, {16'd9, 16'(-9)});
    sample_ready = 1'b1;
    frame(16'd13, 16'(-13), 128, 0, 256);
    chk("drain_count", 32'(got.size()), 32'd3);
    chk("drain_0", got_at(0), {16'd9, 16'(-9)});
    chk("drain_1", got_at(1), {16'd10, 16'(-10)});
    chk("drain_next", got_at(2), {16'd13, 16'(-13)});
    chk("ovf_sticky", 32'(overflow), 32'h1);

    // Early rising lrck at idx 124
    got.delete();
    err_pulses = 0;
    frame(16'h1234, 16'h5678, 124, 0, 256);
    chk("early_err_idx", 32'(err_at), 32'd124);
    chk("early_unlocked", 32'(lock_at_err), 32'h0);
    chk("early_no_pair", 32'(got.size()), 32'd0);
    chk("early_one_pulse", 32'(err_pulses), 32'd1);
    frame(16'hA5A5, 16'h5A5A, 128, 0, 256);
    chk("early_relock", 32'(lock_p0), 32'h1);
    chk("early_next_pair", got_at(0), 32'hA5A5_5A5A);
    chk("early_next_count", 32'(got.size()), 32'd1);

    // lrck stuck low for 300 cycles
    got.delete();
    frame(16'h0, 16'h0, 300, 0, 300);
    chk("stuck_err_idx", 32'(err_at), 32'd128);
    chk("stuck_unlocked", 32'(lock_at_err), 32'h0);
    frame(16'h0, 16'h0, 0, 0, 20);
    chk("stuck_still_unlocked", 32'(locked), 32'h0);
    frame(16'h0F0F, 16'hF0F0, 128, 0, 256);
    chk("stuck_relock", 32'(lock_p0), 32'h1);
    chk("stuck_next_pair", got_at(0), 32'h0F0F_F0F0);

    // Reset asserted at idx 100
    frame(16'h7FFF, 16'h8000, 128, 0, 100);
    chk("pre_rst_locked", 32'(locked), 32'h1);
    chk("pre_rst_hold", {sound_l, sound_r}, 32'h0F0F_F0F0);
    reset = 1'b1;
    step(1'b0, 1'b0);
    reset = 1'b0;
    chk("mid_rst_sound", {sound_l, sound_r}, 32'h0);
    chk("mid_rst_locked", 32'(locked), 32'h0);
    chk("mid_rst_ovf", 32'(overflow), 32'h0);
    chk("mid_rst_valid", 32'(sample_valid), 32'h0);
    frame(16'h7FFF, 16'h8000, 128, 101, 256);
    got.delete();
    frame(16'h7FFF, 16'h8000, 128, 0, 256);
    chk("post_rst_relock", 32'(lock_p0), 32'h1);
    chk("post_rst_pair", got_at(0), 32'h7FFF_8000);
    chk("post_rst_no_ovf", 32'(overflow), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
